pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter / next-PC unit for the single-issue RISC-V core. Selects the next fetch address from these sources:
- sequential increment
- conditional branch
- PC-relative jump
- register jump

It adds fetch stall with a held pending redirect, misaligned-target trapping and a parametrised halt window. It sits at the head of fetch, drives the instruction-memory address and takes its redirect inputs from execute.

Parameters:
XLEN, 32, PC / datapath width in bits
RESET_VEC, 0, PC value loaded by reset
PC_LIMIT, 100, unsigned PC bound; PC >= PC_LIMIT halts the core; 0 disables the check
HALT_VEC, 128, PC value parked at on halt
TRAP_VEC, 'h1C0, PC value loaded on a misaligned redirect target
BR_SHIFT, 1, left shift applied to the branch immediate (offset scaling)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  fetch stall; holds PC
branch_sel  input  1  conditional branch taken (from execute)
jump  input  2  2'b11 PC-relative jump (JAL), 2'b01 register jump (JALR); other codes = none
immediate  input  XLEN  sign-extended offset
alu_result  input  XLEN  JALR target base+offset
counter  output  XLEN  current fetch PC (registered)
pc_plus4  output  XLEN  counter + 4 (combinational, wraps mod 2^XLEN)
pc_valid  output  1  counter is a live fetch address
flush  output  1  registered 1-cycle pulse: counter was just loaded from a non-sequential source
misaligned  output  1  registered 1-cycle pulse: last redirect target had target[1:0] != 0
halted  output  1  core is parked at HALT_VEC

Behaviour:
- Reset is synchronous and active-high; there is one clock. When rst=1 at an edge, the following load on that edge, overriding everything:
  - counter=RESET_VEC, state=RUN
  - pending buffer cleared
  - flush=0, misaligned=0, halted=0
- Targets, all computed mod 2^XLEN on the current counter:
  - branch: counter + (immediate << BR_SHIFT)
  - JAL: counter + immediate
  - JALR: {alu_result[XLEN-1:1],1'b0}
- Redirect priority: branch_sel > jump==11 > jump==01. A redirect is "requested" when any of these is active.
- States:
  - RUN: pc_valid=1.
  - PEND: pc_valid=0; one target held in pend_tgt.
  - HALT: pc_valid=0, halted=1.
- RUN, evaluated in this order per edge:
  1. If PC_LIMIT!=0 and counter >= PC_LIMIT: counter<=HALT_VEC, go to HALT. Any redirect is dropped. Stall is ignored.
  2. Else if a redirect is requested and stall=1: pend_tgt<=target, go to PEND. counter holds.
  3. Else if a redirect is requested: load the target (see misalignment rule below).
  4. Else if stall=1: counter holds.
  5. Else: counter<=counter+4.
- PEND:
  - Further redirect inputs are ignored; the first captured target wins.
  - When stall=0: apply pend_tgt (see misalignment rule), go to RUN.
  - Otherwise hold.
- Target load / misalignment rule:
  - If target[1:0]==0: counter<=target.
  - Otherwise: counter<=TRAP_VEC and misaligned pulses next cycle.
  - flush pulses 1 cycle after any target or trap load.
- HALT is absorbing until rst. counter stays HALT_VEC and all inputs are ignored.
- The limit check uses the pre-update counter. The halt-transition cycle does not assert flush.
- Latency:
  - Sequential and redirect updates take effect at the next edge.
  - A stalled redirect takes effect at the first edge with stall=0.
- No combinational path from inputs to counter, flush, misaligned or halted.

Test Plan:
1. Reset then 3 free-running cycles (no redirects, stall=0) -> counter 0,4,8,12; pc_valid=1; flush=0.
2. At counter=8: branch_sel=1, immediate=6, and jump=11 in the same cycle -> counter=20 (branch wins, 8+6<<1); flush=1 for exactly 1 cycle.
3. At counter=12 with stall=1:
   - JALR with alu_result=0x41 -> state PEND, pc_valid=0, counter=12.
   - Next cycle, also stall=1: branch_sel=1 -> that redirect is ignored.
   - stall drops -> counter=0x40, flush pulses once.
4. JAL with immediate=2 at counter=16 -> counter=TRAP_VEC ('h1C0), misaligned=1 and flush=1 for one cycle.
5. Sequential run reaching counter=100, with stall=1 and branch_sel=1 asserted -> next counter=128, halted=1, pc_valid=0. Holds for 5 cycles despite redirects. rst=1 -> counter=0, halted=0.
6. Parameter sweep:
   - XLEN=16, PC_LIMIT=0: counter wraps 0xFFFC -> 0x0000 with no halt.
   - XLEN=16, PC_LIMIT=0, rst asserted while in PEND -> pending target discarded, counter=RESET_VEC.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter / next-PC unit at the head of fetch: sequential, branch, JAL and JALR
// redirects, stall with a held pending redirect, misaligned-target trap and limit halt.
module pc_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [XLEN-1:0]  PC_LIMIT  = XLEN'(100),
  parameter logic [XLEN-1:0]  HALT_VEC  = XLEN'(128),
  parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'('h1C0),
  parameter int unsigned      BR_SHIFT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_sel,
  input  logic [1:0]      jump,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] counter,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            flush,
  output logic            misaligned,
  output logic            halted
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] JUMP_JAL  = 2'b11;
  localparam logic [1:0] JUMP_JALR = 2'b01;

  localparam bit LIMIT_EN = (PC_LIMIT != '0);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] counter_d;
  logic            flush_d;
  logic            mis_d;

  logic            redir_req;
  logic [XLEN-1:0] redir_tgt;
  logic            load_req;
  logic [XLEN-1:0] load_tgt;

  assign pc_plus4 = counter + XLEN'(4);

  // Redirect source select, branch highest priority
  always_comb begin
    redir_req = 1'b0;
    redir_tgt = '0;
    if (branch_sel) begin
      redir_req = 1'b1;
      redir_tgt = counter + (immediate << BR_SHIFT);
    end else if (jump == JUMP_JAL) begin
      redir_req = 1'b1;
      redir_tgt = counter + immediate;
    end else if (jump == JUMP_JALR) begin
      redir_req = 1'b1;
      redir_tgt = alu_result & ~XLEN'(1);
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d   = state_q;
    counter_d = counter;
    pend_d    = pend_q;
    flush_d   = 1'b0;
    mis_d     = 1'b0;
    load_req  = 1'b0;
    load_tgt  = '0;

    case (state_q)
      ST_RUN: begin
        if (LIMIT_EN && (counter >= PC_LIMIT)) begin
          counter_d = HALT_VEC;
          state_d   = ST_HALT;
        end else if (redir_req && stall) begin
          pend_d  = redir_tgt;
          state_d = ST_PEND;
        end else if (redir_req) begin
          load_req = 1'b1;
          load_tgt = redir_tgt;
        end else if (!stall) begin
          counter_d = pc_plus4;
        end
      end
      ST_PEND: begin
        // First captured target wins; new redirects are ignored while pending
        if (!stall) begin
          load_req = 1'b1;
          load_tgt = pend_q;
          state_d  = ST_RUN;
        end
      end
      ST_HALT: begin
        counter_d = HALT_VEC;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Misaligned targets are diverted to the trap vector
    if (load_req) begin
      flush_d = 1'b1;
      if (load_tgt[1:0] != 2'b00) begin
        counter_d = TRAP_VEC;
        mis_d     = 1'b1;
      end else begin
        counter_d = load_tgt;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      counter    <= RESET_VEC;
      pend_q     <= '0;
      flush      <= 1'b0;
      misaligned <= 1'b0;
      halted     <= 1'b0;
      pc_valid   <= 1'b1;
    end else begin
      state_q    <= state_d;
      counter    <= counter_d;
      pend_q     <= pend_d;
      flush      <= flush_d;
      misaligned <= mis_d;
      halted     <= (state_d == ST_HALT);
      pc_valid   <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: default 32-bit instance plus a 16-bit
// instance with the limit check disabled.
module tb_pc_unit;

  logic        clk;
  logic        rst, stall, branch_sel;
  logic [1:0]  jump;
  logic [31:0] immediate, alu_result;
  logic [31:0] counter, pc_plus4;
  logic        pc_valid, flush, misaligned, halted;

  logic        rst16, stall16, branch_sel16;
  logic [1:0]  jump16;
  logic [15:0] immediate16, alu_result16;
  logic [15:0] counter16, pc_plus4_16;
  logic        pc_valid16, flush16, misaligned16, halted16;

  int n_cmp;
  int n_err;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_sel(branch_sel), .jump(jump),
    .immediate(immediate), .alu_result(alu_result), .counter(counter),
    .pc_plus4(pc_plus4), .pc_valid(pc_valid), .flush(flush),
    .misaligned(misaligned), .halted(halted)
  );

  pc_unit #(.XLEN(16), .PC_LIMIT(16'd0)) dut16 (
    .clk(clk), .rst(rst16), .stall(stall16), .branch_sel(branch_sel16), .jump(jump16),
    .immediate(immediate16), .alu_result(alu_result16), .counter(counter16),
    .pc_plus4(pc_plus4_16), .pc_valid(pc_valid16), .flush(flush16),
    .misaligned(misaligned16), .halted(halted16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; branch_sel = 1'b0; jump = 2'b00; immediate = '0; alu_result = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst16 = 1'b1; stall16 = 1'b0; branch_sel16 = 1'b0; jump16 = 2'b00;
    immediate16 = '0; alu_result16 = '0;

    // Reset and free-running sequence
    do_reset();
    check_eq("rst_counter", counter, 32'd0);
    check_eq("rst_valid", 32'(pc_valid), 32'd1);
    check_eq("rst_flush", 32'(flush), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_mis", 32'(misaligned), 32'd0);
    check_eq("rst_plus4", pc_plus4, 32'd4);
    tick();
    check_eq("seq_4", counter, 32'd4);
    tick();
    check_eq("seq_8", counter, 32'd8);
    check_eq("seq_flush", 32'(flush), 32'd0);

    // Branch beats JAL in the same cycle: 8 + (6<<1) = 20
    branch_sel = 1'b1; immediate = 32'd6; jump = 2'b11;
    tick();
    idle();
    check_eq("br_counter", counter, 32'd20);
    check_eq("br_flush", 32'(flush), 32'd1);
    tick();
    check_eq("br_after", counter, 32'd24);
    check_eq("br_flush_off", 32'(flush), 32'd0);

    // Stalled JALR is held; later redirect while pending is ignored
    do_reset();
    tick(); tick(); tick();
    check_eq("pend_start", counter, 32'd12);
    stall = 1'b1; jump = 2'b01; alu_result = 32'h41;
    tick();
    check_eq("pend_counter", counter, 32'd12);
    check_eq("pend_valid", 32'(pc_valid), 32'd0);
    jump = 2'b00; alu_result = '0; branch_sel = 1'b1; immediate = 32'd100;
    tick();
    check_eq("pend_hold", counter, 32'd12);
    check_eq("pend_flush", 32'(flush), 32'd0);
    idle();
    tick();
    check_eq("pend_apply", counter, 32'h40);
    check_eq("pend_apply_flush", 32'(flush), 32'd1);
    check_eq("pend_apply_valid", 32'(pc_valid), 32'd1);
    tick();
    check_eq("pend_seq", counter, 32'h44);
    check_eq("pend_flush_off", 32'(flush), 32'd0);

    // Misaligned JAL target (16 + 2) traps
    do_reset();
    tick(); tick(); tick(); tick();
    check_eq("trap_start", counter, 32'd16);
    jump = 2'b11; immediate = 32'd2;
    tick();
    idle();
    check_eq("trap_counter", counter, 32'h1C0);
    check_eq("trap_mis", 32'(misaligned), 32'd1);
    check_eq("trap_flush", 32'(flush), 32'd1);
    tick();
    check_eq("trap_halt", counter, 32'd128);
    check_eq("trap_mis_off", 32'(misaligned), 32'd0);
    check_eq("trap_halted", 32'(halted), 32'd1);

    // Sequential run to the limit, halt despite stall and branch
    do_reset();
    for (int i = 0; i < 25; i++) tick();
    check_eq("lim_at100", counter, 32'd100);
    check_eq("lim_not_halted", 32'(halted), 32'd0);
    stall = 1'b1; branch_sel = 1'b1; immediate = 32'd4;
    tick();
    check_eq("lim_counter", counter, 32'd128);
    check_eq("lim_halted", 32'(halted), 32'd1);
    check_eq("lim_valid", 32'(pc_valid), 32'd0);
    check_eq("lim_flush", 32'(flush), 32'd0);
    for (int i = 0; i < 5; i++) begin
      stall = 1'(i % 2); branch_sel = 1'b0; jump = 2'b11; immediate = 32'd8;
      tick();
      check_eq("halt_hold", counter, 32'd128);
      check_eq("halt_flag", 32'(halted), 32'd1);
    end
    do_reset();
    check_eq("halt_rst_counter", counter, 32'd0);
    check_eq("halt_rst_halted", 32'(halted), 32'd0);

    // 16-bit instance: wrap without halt
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    jump16 = 2'b01; alu_result16 = 16'hFFF8;
    tick();
    jump16 = 2'b00; alu_result16 = '0;
    check_eq("w16_jalr", 32'(counter16), 32'h0000FFF8);
    check_eq("w16_flush", 32'(flush16), 32'd1);
    tick();
    check_eq("w16_fffc", 32'(counter16), 32'h0000FFFC);
    check_eq("w16_plus4", 32'(pc_plus4_16), 32'd0);
    tick();
    check_eq("w16_wrap", 32'(counter16), 32'd0);
    check_eq("w16_nohalt", 32'(halted16), 32'd0);
    check_eq("w16_valid", 32'(pc_valid16), 32'd1);

    // 16-bit instance: reset while pending discards the target
    stall16 = 1'b1; jump16 = 2'b01; alu_result16 = 16'h0100;
    tick();
    check_eq("p16_valid", 32'(pc_valid16), 32'd0);
    check_eq("p16_counter", 32'(counter16), 32'd0);
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0; stall16 = 1'b0; jump16 = 2'b00; alu_result16 = '0;
    check_eq("p16_rst_counter", 32'(counter16), 32'd0);
    check_eq("p16_rst_valid", 32'(pc_valid16), 32'd1);
    tick();
    check_eq("p16_discard", 32'(counter16), 32'd4);
    check_eq("p16_flush", 32'(flush16), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
